// File: rtl/bitidx_gen.sv
// bitidx_gen: enumerates the set-bit indices of an operand, one valid/ready beat per cycle.
// Optional BITIDX_REVERSE_EN adds a Rev port selecting MSB-first order.
module bitidx_gen #(
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         A,
    input  logic                     W64,
`ifdef BITIDX_REVERSE_EN
    input  logic                     Rev,
`endif
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [$clog2(WIDTH)-1:0] Idx,
    output logic                     Last,
    output logic                     Empty,
    output logic [$clog2(WIDTH):0]   Total
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LO_MASK = WIDTH'(32'hFFFF_FFFF);
    localparam logic [IW:0] CNT_ONE = 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_n;
    logic [WIDTH-1:0] r, masked;
    logic [IW:0] cnt;
    logic e, single;
    logic [IW-1:0] lo, enc;
`ifdef BITIDX_REVERSE_EN
    logic rev_q;
    logic [IW-1:0] hi;
`endif

    assign masked = (WIDTH == 64 && W64) ? (A & LO_MASK) : A;
    assign single = (r != '0) && ((r & (r - WIDTH'(1))) == '0);

    // Later matches overwrite earlier ones, so loop direction picks lowest or highest bit.
    always_comb begin
        lo = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (r[i]) lo = IW'(i);
`ifdef BITIDX_REVERSE_EN
        hi = '0;
        for (int i = 0; i < WIDTH; i++)
            if (r[i]) hi = IW'(i);
        enc = rev_q ? hi : lo;
`else
        enc = lo;
`endif
    end

    always_comb begin
        state_n  = state;
        InReady  = 1'b0;
        OutValid = 1'b0;
        Idx      = '0;
        Last     = 1'b0;
        Empty    = 1'b0;
        Total    = '0;
        if (state == IDLE) begin
            InReady = !reset;
            state_n = InValid ? EMIT : IDLE;
        end else begin
            OutValid = 1'b1;
            Idx      = enc;
            Last     = e || single;
            Empty    = e;
            Total    = e ? '0 : cnt;
            state_n  = (OutReady && Last) ? IDLE : EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r     <= '0;
            cnt   <= '0;
            e     <= 1'b0;
`ifdef BITIDX_REVERSE_EN
            rev_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && InValid) begin
                r     <= masked;
                cnt   <= CNT_ONE;
                e     <= (masked == '0);
`ifdef BITIDX_REVERSE_EN
                rev_q <= Rev;
`endif
            end else if (state == EMIT && OutReady) begin
                if (Last) begin
                    r <= '0;
                end else begin
                    r   <= r & ~(WIDTH'(1) << enc);
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bitidx_gen.sv
// tb_bitidx_gen: directed operands with a reference beat queue checked by an independent monitor.
module tb_bitidx_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [63:0] A = '0;
    logic        W64 = 1'b0;
`ifdef BITIDX_REVERSE_EN
    logic        rev = 1'b0;
`endif
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [5:0]  Idx;
    logic        Last;
    logic        Empty;
    logic [6:0]  Total;

    typedef struct {
        logic [5:0] idx;
        logic       last;
        logic       empty;
        logic [6:0] total;
    } beat_t;

    beat_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int pops = 0;
    int cyc = 0;

    bitidx_gen #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .A(A), .W64(W64),
`ifdef BITIDX_REVERSE_EN
        .Rev(rev),
`endif
        .OutValid(OutValid), .OutReady(OutReady), .Idx(Idx), .Last(Last), .Empty(Empty), .Total(Total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [63:0] a, input bit w, input bit rv);
        logic [63:0] m;
        int pc, cnt, i;
        m = w ? {32'b0, a[31:0]} : a;
        pc = $countones(m);
        cnt = 0;
        if (pc == 0) q.push_back('{6'd0, 1'b1, 1'b1, 7'd0});
        for (int k = 0; k < 64; k++) begin
            i = rv ? 63 - k : k;
            if (m[i]) begin
                cnt++;
                q.push_back('{6'(i), cnt == pc, 1'b0, 7'(cnt)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && OutValid) begin
            check("inready_in_emit", InReady, 0);
            if (q.size() == 0) begin
                check("unexpected_beat", OutValid, 0);
            end else begin
                check("idx", Idx, q[0].idx);
                check("last", Last, q[0].last);
                check("empty", Empty, q[0].empty);
                check("total", Total, q[0].total);
                if (OutReady) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input bit w, input bit rv, input bit keep, output int acc);
        bit ok = 0;
        acc = -1;
        InValid = 1'b1;
        A = a;
        W64 = w;
`ifdef BITIDX_REVERSE_EN
        rev = rv;
`endif
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (InReady) begin
                push_expected(a, w, rv);
                acc = cyc;
                ok = 1;
            end
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        if (!keep) InValid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int p = 0;
        for (int c = 0; c < 400 && q.size() != 0; c++) begin
            OutReady = toggle ? (p % 4 == 0 || p % 4 == 3) : 1'b1;
            p++;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", q.size(), 0);
        OutReady = 1'b1;
        @(negedge clk);
        check("inready_after", InReady, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc1, acc2, base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inready", InReady, 0);
        check("rst_outvalid", OutValid, 0);
        check("rst_idx", Idx, 0);
        check("rst_last", Last, 0);
        check("rst_empty", Empty, 0);
        check("rst_total", Total, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_inready", InReady, 1);
        @(posedge clk);
        #1;

        send(64'h0000_0000_8000_0011, 0, 0, 0, acc1);
        drain(0);
        send(64'h0, 0, 0, 0, acc1);
        drain(0);
        send(64'hFFFF_FFFF_0000_0000, 1, 0, 0, acc1);
        drain(0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, acc1);
        drain(1);
        send(64'hF000_0000_0000_0005, 1, 0, 0, acc1);
        drain(0);
`ifdef BITIDX_REVERSE_EN
        send(64'hF000_0000_0000_0005, 1, 1, 0, acc1);
        drain(0);
        send(64'h8000_0000_0001_0000, 0, 1, 0, acc1);
        drain(1);
`endif

        base = pops;
        send(64'hFF, 0, 0, 0, acc1);
        for (int c = 0; c < 50 && pops - base < 2; c++) begin
            @(posedge clk);
            #1;
        end
        check("mid_two_beats", pops - base, 2);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_outvalid", OutValid, 0);
        check("mid_rst_inready", InReady, 1);
        check("mid_rst_total", Total, 0);
        @(posedge clk);
        #1;
        send(64'h2, 0, 0, 0, acc1);
        drain(0);

        send(64'h0000_0000_0000_0104, 0, 0, 1, acc1);
        A = 64'hFFFF;
        @(negedge clk);
        check("overlap_blocked", InReady, 0);
        @(posedge clk);
        #1;
        send(64'h8000_0000_0000_0000, 0, 0, 0, acc2);
        check("overlap_gap", acc2 - acc1, 3);
        drain(0);

        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
